// File: rtl/ddram_responder_if.sv
// ddram_responder_if
//   DDRAM_* burst bus between a DDRAM client (master) and the memory side
//   (slave). Clock and reset are carried as plain ports outside the bundle.
//   Signals:
//     DDRAM_BUSY        slave->master  waitrequest
//     DDRAM_BURSTCNT    master->slave  beats in burst
//     DDRAM_ADDR        master->slave  quadword address
//     DDRAM_RD          master->slave  read command
//     DDRAM_DOUT        slave->master  read beat data
//     DDRAM_DOUT_READY  slave->master  read beat valid
//     DDRAM_DIN         master->slave  write beat data
//     DDRAM_BE          master->slave  write byte enables
//     DDRAM_WE          master->slave  write beat request
interface ddram_responder_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddram_responder.sv
// ddram_responder
//   Memory end of the DDRAM_* burst bus. Serves read and write bursts from a
//   local 64-bit RAM of 2^ADDR_W quadwords mapped at quadword window BASE.
//   Used in place of the HPS DDR port in simulation and bring-up builds.
//   Ports:
//     DDRAM_CLK    sole clock
//     DDRAM_RST_N  asynchronous active-low reset
//     bus          DDRAM_* bus, slave side
//     stall        test hook, forces DDRAM_BUSY high while set
//     err          one-cycle pulse on protocol or window error
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for a write beat or read command
//   WR_BURST | collecting remaining write beats, gaps allowed
//   RD_WAIT  | read accepted, counting down to the first beat
//   RD_BURST | one read beat per cycle on DDRAM_DOUT, DOUT_READY high
module ddram_responder #(
    parameter int          ADDR_W = 12,
    parameter logic [28:0] BASE   = 29'h0600000,
    parameter int          RD_LAT = 4
) (
    input  logic                DDRAM_CLK,
    input  logic                DDRAM_RST_N,
    ddram_responder_if.slave    bus,
    input  logic                stall,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

    // First beat is loaded on the edge where the counter sits at zero, which
    // is RD_LAT edges after the accept edge.
    localparam logic [3:0]        LAT_LOAD = 4'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          rem_q, rem_d;
    logic [3:0]          lat_q, lat_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;
    logic [63:0]         dout_q;
    logic                beat_ld;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;

    logic [63:0]         mem [2**ADDR_W];

    logic                busy;
    logic                in_win;
    logic                bc_zero;
    logic [7:0]          burst_eff;
    logic [ADDR_W-1:0]   cmd_idx;
    logic                we_acc;
    logic                rd_acc;

    assign busy      = stall | (state_q == RD_WAIT) | (state_q == RD_BURST);
    assign in_win    = (bus.DDRAM_ADDR[28:ADDR_W] == BASE[28:ADDR_W]);
    assign bc_zero   = (bus.DDRAM_BURSTCNT == 8'd0);
    assign burst_eff = bc_zero ? 8'd1 : bus.DDRAM_BURSTCNT;
    assign cmd_idx   = bus.DDRAM_ADDR[ADDR_W-1:0];
    assign we_acc    = bus.DDRAM_WE & ~busy;
    assign rd_acc    = bus.DDRAM_RD & ~busy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
        hit_d   = hit_q;
        err_d   = 1'b0;
        beat_ld = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = addr_q;
        case (state_q)
            IDLE: begin
                if (we_acc) begin
                    // Write wins over a simultaneous read; the read is dropped.
                    wr_idx = cmd_idx;
                    wr_en  = in_win;
                    err_d  = ~in_win | bc_zero | bus.DDRAM_RD;
                    if (burst_eff > 8'd1) begin
                        state_d = WR_BURST;
                        addr_d  = cmd_idx + IDX_ONE;
                        rem_d   = burst_eff - 8'd1;
                        hit_d   = in_win;
                    end
                end else if (rd_acc) begin
                    state_d = RD_WAIT;
                    addr_d  = cmd_idx;
                    rem_d   = burst_eff;
                    hit_d   = in_win;
                    lat_d   = LAT_LOAD;
                    err_d   = ~in_win | bc_zero;
                end
            end
            WR_BURST: begin
                err_d = bus.DDRAM_RD;
                if (we_acc) begin
                    wr_en  = hit_q;
                    addr_d = addr_q + IDX_ONE;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == 4'd0) begin
                    beat_ld = 1'b1;
                    state_d = RD_BURST;
                    addr_d  = addr_q + IDX_ONE;
                    rem_d   = rem_q - 8'd1;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RD_BURST: begin
                // rem_q counts beats not yet loaded; zero means the beat on
                // the bus now is the last one.
                if (rem_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    beat_ld = 1'b1;
                    addr_d  = addr_q + IDX_ONE;
                    rem_d   = rem_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RST_N) begin
        if (!DDRAM_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RST_N) begin
        if (!DDRAM_RST_N) begin
            addr_q <= '0;
            rem_q  <= 8'd0;
            lat_q  <= 4'd0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
            dout_q <= 64'h0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            lat_q  <= lat_d;
            hit_q  <= hit_d;
            err_q  <= err_d;
            // Synchronous read port; a miss window returns zero beats.
            if (beat_ld) begin
                dout_q <= hit_q ? mem[addr_q] : 64'h0;
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.DDRAM_BE[b]) begin
                    mem[wr_idx][8*b +: 8] <= bus.DDRAM_DIN[8*b +: 8];
                end
            end
        end
    end

    assign bus.DDRAM_BUSY       = busy;
    assign bus.DDRAM_DOUT       = dout_q;
    assign bus.DDRAM_DOUT_READY = (state_q == RD_BURST);
    assign err                  = err_q;

endmodule

// File: tb/tb_ddram_responder.sv
module tb_ddram_responder;
    localparam logic [28:0] BASE   = 29'h0600000;
    localparam int          RD_LAT = 4;

    logic clk;
    logic rst_n;
    logic stall;
    logic err;
    int   errors;
    int   checks;
    int   err_cnt;
    int   e0;
    logic [63:0] rd_beats [16];

    ddram_responder_if bus();

    ddram_responder #(.ADDR_W(12), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
        .DDRAM_CLK   (clk),
        .DDRAM_RST_N (rst_n),
        .bus         (bus),
        .stall       (stall),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial err_cnt = 0;
    always @(negedge clk) if (err === 1'b1) err_cnt = err_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after the accept edge; collects n beats.
    task automatic wait_beats(input int n);
        for (int k = 0; k < RD_LAT; k++) begin
            check("lat_no_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
            check("lat_busy", {63'h0, bus.DDRAM_BUSY}, 64'h1);
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            check("beat_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h1);
            rd_beats[i] = bus.DDRAM_DOUT;
            @(negedge clk);
        end
        check("end_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
        check("end_busy", {63'h0, bus.DDRAM_BUSY}, 64'h0);
        check("dout_hold", bus.DDRAM_DOUT, rd_beats[n-1]);
    endtask

    task automatic do_read(input logic [28:0] a, input logic [7:0] n);
        @(negedge clk);
        bus.DDRAM_RD = 1'b1; bus.DDRAM_ADDR = a; bus.DDRAM_BURSTCNT = n;
        @(negedge clk);
        bus.DDRAM_RD = 1'b0;
        wait_beats((n == 8'd0) ? 1 : int'(n));
    endtask

    task automatic write1(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be, input logic [7:0] n);
        @(negedge clk);
        bus.DDRAM_WE = 1'b1; bus.DDRAM_ADDR = a; bus.DDRAM_DIN = d;
        bus.DDRAM_BE = be; bus.DDRAM_BURSTCNT = n;
        @(negedge clk);
        bus.DDRAM_WE = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; stall = 1'b0;
        bus.DDRAM_RD = 1'b0; bus.DDRAM_WE = 1'b0; bus.DDRAM_ADDR = '0;
        bus.DDRAM_BURSTCNT = 8'd1; bus.DDRAM_DIN = '0; bus.DDRAM_BE = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'h0, bus.DDRAM_BUSY}, 64'h0);
        check("rst_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
        check("rst_dout", bus.DDRAM_DOUT, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single write then read
        e0 = err_cnt;
        write1(BASE + 29'd5, 64'h1122334455667788, 8'hFF, 8'd1);
        do_read(BASE + 29'd5, 8'd1);
        check("t1_data", rd_beats[0], 64'h1122334455667788);
        check("t1_no_err", 64'(err_cnt - e0), 64'h0);

        // 2: byte-lane merge
        write1(BASE + 29'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0C, 8'd1);
        do_read(BASE + 29'd5, 8'd1);
        check("t2_merge", rd_beats[0], 64'h11223344_FFFF7788);

        // 3: gapped write burst across the wrap, read back
        e0 = err_cnt;
        @(negedge clk);
        bus.DDRAM_WE = 1'b1; bus.DDRAM_ADDR = BASE + 29'd4094; bus.DDRAM_BURSTCNT = 8'd4;
        bus.DDRAM_BE = 8'hFF; bus.DDRAM_DIN = 64'd1;
        @(negedge clk); bus.DDRAM_DIN = 64'd2; bus.DDRAM_ADDR = 29'h0;
        @(negedge clk); bus.DDRAM_WE = 1'b0;
        repeat (2) @(negedge clk);
        bus.DDRAM_WE = 1'b1; bus.DDRAM_DIN = 64'd3;
        @(negedge clk); bus.DDRAM_DIN = 64'd4;
        @(negedge clk); bus.DDRAM_WE = 1'b0;
        do_read(BASE + 29'd4094, 8'd4);
        for (int i = 0; i < 4; i++) check("t3_beat", rd_beats[i], 64'(i + 1));
        do_read(BASE, 8'd2);
        check("t3_idx0", rd_beats[0], 64'd3);
        check("t3_idx1", rd_beats[1], 64'd4);
        check("t3_no_err", 64'(err_cnt - e0), 64'h0);

        // 4: stalled read command, then 8-beat read
        @(negedge clk);
        bus.DDRAM_WE = 1'b1; bus.DDRAM_ADDR = BASE + 29'd16; bus.DDRAM_BURSTCNT = 8'd8;
        for (int i = 0; i < 8; i++) begin
            bus.DDRAM_DIN = 64'h100 + 64'(i);
            @(negedge clk);
        end
        bus.DDRAM_WE = 1'b0;
        stall = 1'b1;
        bus.DDRAM_RD = 1'b1; bus.DDRAM_ADDR = BASE + 29'd16; bus.DDRAM_BURSTCNT = 8'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_busy", {63'h0, bus.DDRAM_BUSY}, 64'h1);
            check("t4_stall_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
        end
        stall = 1'b0;
        @(negedge clk);
        bus.DDRAM_RD = 1'b0;
        wait_beats(8);
        for (int i = 0; i < 8; i++) check("t4_beat", rd_beats[i], 64'h100 + 64'(i));

        // 5: window miss read and write
        e0 = err_cnt;
        do_read(29'h0, 8'd2);
        check("t5_rd0", rd_beats[0], 64'h0);
        check("t5_rd1", rd_beats[1], 64'h0);
        check("t5_rd_err", 64'(err_cnt - e0), 64'h1);
        e0 = err_cnt;
        write1(29'h0, 64'hDEAD_BEEF_0000_0000, 8'hFF, 8'd1);
        @(negedge clk);
        check("t5_wr_err", 64'(err_cnt - e0), 64'h1);
        do_read(BASE, 8'd1);
        check("t5_ram_kept", rd_beats[0], 64'd3);

        // BURSTCNT=0 acts as one beat and flags err
        e0 = err_cnt;
        write1(BASE + 29'd6, 64'hA5A5_0000_1234_5678, 8'hFF, 8'd0);
        @(negedge clk);
        check("bc0_err", 64'(err_cnt - e0), 64'h1);
        do_read(BASE + 29'd6, 8'd1);
        check("bc0_data", rd_beats[0], 64'hA5A5_0000_1234_5678);

        // RD and WE together: write wins, no read beats, err
        e0 = err_cnt;
        @(negedge clk);
        bus.DDRAM_RD = 1'b1; bus.DDRAM_WE = 1'b1; bus.DDRAM_ADDR = BASE + 29'd7;
        bus.DDRAM_BURSTCNT = 8'd1; bus.DDRAM_DIN = 64'h77; bus.DDRAM_BE = 8'hFF;
        @(negedge clk);
        bus.DDRAM_RD = 1'b0; bus.DDRAM_WE = 1'b0;
        check("both_busy", {63'h0, bus.DDRAM_BUSY}, 64'h0);
        for (int i = 0; i < RD_LAT + 2; i++) begin
            check("both_no_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
            @(negedge clk);
        end
        check("both_err", 64'(err_cnt - e0), 64'h1);
        do_read(BASE + 29'd7, 8'd1);
        check("both_data", rd_beats[0], 64'h77);

        // 6: reset during beat 3 of an 8-beat read
        @(negedge clk);
        bus.DDRAM_RD = 1'b1; bus.DDRAM_ADDR = BASE + 29'd16; bus.DDRAM_BURSTCNT = 8'd8;
        @(negedge clk);
        bus.DDRAM_RD = 1'b0;
        repeat (RD_LAT + 2) @(negedge clk);
        check("t6_beat3", bus.DDRAM_DOUT, 64'h102);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", {63'h0, bus.DDRAM_DOUT_READY}, 64'h0);
        check("t6_rst_busy", {63'h0, bus.DDRAM_BUSY}, 64'h0);
        check("t6_rst_dout", bus.DDRAM_DOUT, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_read(BASE + 29'd16, 8'd2);
        check("t6_after0", rd_beats[0], 64'h100);
        check("t6_after1", rd_beats[1], 64'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
